// File: rtl/fetch_if.sv
// fetch_if: imem request/response, redirect and decode handshake bundle for fetch_stage
interface fetch_if #(
  parameter int XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_instr;
  logic [XLEN-1:0] if_pc;
  modport master (
    output imem_req_valid, imem_addr, if_valid, if_instr, if_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, if_ready
  );
  modport slave (
    input  imem_req_valid, imem_addr, if_valid, if_instr, if_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, if_ready
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: PC generation, imem request issue and instruction FIFO toward decode
module fetch_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input logic     clk,
  input logic     reset,
  fetch_if.master bus
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] CAP = DEPTH[CW:0];
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] instr_q [DEPTH];
  logic [XLEN-1:0] pc_q [DEPTH];
  logic [XLEN-1:0] tag_q [DEPTH];
  logic [AW-1:0]   head, tail, tag_head, tag_tail;
  logic [CW-1:0]   count, outstanding, drop, outstanding_next;
  logic [CW:0]     inflight;
  logic            req_fire, push, pop;
  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  assign inflight              = outstanding + count;
  assign bus.imem_req_valid    = !reset && !bus.redirect_valid && (inflight < CAP);
  assign bus.imem_addr         = fetch_pc;
  assign req_fire              = bus.imem_req_valid && bus.imem_req_ready;
  assign push                  = bus.imem_rsp_valid && drop == '0 && !bus.redirect_valid;
  assign pop                   = bus.if_valid && bus.if_ready && !bus.redirect_valid;
  assign outstanding_next      = outstanding + CW'(req_fire) - CW'(bus.imem_rsp_valid);
  assign bus.if_valid          = count != '0;
  assign bus.if_instr          = bus.if_valid ? instr_q[head] : '0;
  assign bus.if_pc             = bus.if_valid ? pc_q[head] : '0;
  // Control state: PC, counters and pointers; a redirect flushes the FIFO and turns every in-flight request into a drop
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
      head        <= '0;
      tail        <= '0;
      tag_head    <= '0;
      tag_tail    <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (req_fire) tag_tail <= inc(tag_tail);
      if (bus.imem_rsp_valid) tag_head <= inc(tag_head);
      if (bus.redirect_valid) begin
        fetch_pc <= bus.redirect_pc & ~XLEN'(3);
        drop     <= outstanding_next;
        count    <= '0;
        head     <= '0;
        tail     <= '0;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
        if (bus.imem_rsp_valid && drop != '0) drop <= drop - CW'(1);
        if (push) tail <= inc(tail);
        if (pop) head <= inc(head);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end
  // Storage: PC tags follow issue order so each returning word picks up its own PC
  always_ff @(posedge clk) begin
    if (req_fire) tag_q[tag_tail] <= fetch_pc;
    if (push) begin
      instr_q[tail] <= bus.imem_rsp_data;
      pc_q[tail]    <= tag_q[tag_head];
    end
  end
  // The outstanding cap keeps the FIFO from ever being pushed while full
  always_ff @(posedge clk) begin
    if (!reset) assert (!(push && !pop && {1'b0, count} == CAP));
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and random checks of fetch_stage against a queue-based model
module tb_fetch_stage;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  fetch_if #(.XLEN(32)) b();
  fetch_stage #(.XLEN(32), .RESET_PC(32'h0), .DEPTH(2)) dut (.clk(clk), .reset(reset), .bus(b.master));
  typedef struct {logic [31:0] pc; bit stale; int due;} infl_t;
  infl_t       infl[$];
  logic [31:0] buf_pc[$];
  logic [31:0] m_pc;
  int          cyc = 0, fixed_lat = 1, errors = 0, checks = 0;
  bit          rand_lat = 0;
  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0013;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask
  task automatic tick(input bit rdy, input bit ird, input bit redir, input logic [31:0] rpc, input bit rs);
    bit exp_req, exp_ifv, rsp, fire;
    infl_t f;
    int due;
    exp_ifv = buf_pc.size() != 0;
    rsp = !rs && infl.size() != 0 && infl[0].due <= cyc;
    exp_req = !rs && !redir && (infl.size() + buf_pc.size() < 2);
    reset = rs;
    b.imem_req_ready = rdy;
    b.if_ready = ird;
    b.redirect_valid = redir;
    b.redirect_pc = rpc;
    b.imem_rsp_valid = rsp;
    b.imem_rsp_data = rsp ? word(infl[0].pc) : $urandom;
    #2;
    chk("req_valid", 32'(b.imem_req_valid), 32'(exp_req));
    chk("imem_addr", b.imem_addr, m_pc);
    chk("if_valid", 32'(b.if_valid), 32'(exp_ifv));
    if (exp_ifv) begin
      chk("if_pc", b.if_pc, buf_pc[0]);
      chk("if_instr", b.if_instr, word(buf_pc[0]));
    end
    fire = exp_req && rdy;
    if (rs) begin
      infl.delete();
      buf_pc.delete();
      m_pc = 32'h0;
    end else begin
      if (rsp) f = infl.pop_front();
      if (redir) begin
        buf_pc.delete();
        foreach (infl[i]) infl[i].stale = 1'b1;
        m_pc = {rpc[31:2], 2'b00};
      end else begin
        if (exp_ifv && ird) void'(buf_pc.pop_front());
        if (rsp && !f.stale) buf_pc.push_back(f.pc);
        if (fire) begin
          due = cyc + (rand_lat ? int'($urandom_range(1, 3)) : fixed_lat);
          if (infl.size() != 0 && infl[$].due >= due) due = infl[$].due + 1;
          infl.push_back('{m_pc, 1'b0, due});
          m_pc = m_pc + 32'd4;
        end
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [31:0] w;
    reset = 1'b1;
    b.imem_req_ready = 1'b0;
    b.if_ready = 1'b0;
    b.redirect_valid = 1'b0;
    b.redirect_pc = '0;
    b.imem_rsp_valid = 1'b0;
    b.imem_rsp_data = '0;
    m_pc = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_valid", 32'(b.imem_req_valid), 32'h0);
    chk("rst_if_valid", 32'(b.if_valid), 32'h0);
    chk("rst_if_pc", b.if_pc, 32'h0);
    chk("rst_if_instr", b.if_instr, 32'h0);
    chk("rst_imem_addr", b.imem_addr, 32'h0);
    // streaming with 1-cycle imem and decode always ready
    tick(1, 1, 0, 0, 0);
    tick(1, 1, 0, 0, 0);
    w = word(32'h0);
    chk("first_pc", b.if_pc, 32'h0);
    chk("first_opcode", 32'(b.if_instr[6:0]), 32'(w[6:0]));
    repeat (12) tick(1, 1, 0, 0, 0);
    // decode stall: at most two in flight or buffered, issue stops
    repeat (10) tick(1, 0, 0, 0, 0);
    chk("stall_req_valid", 32'(b.imem_req_valid), 32'h0);
    chk("stall_if_valid", 32'(b.if_valid), 32'h1);
    repeat (10) tick(1, 1, 0, 0, 0);
    // redirect with two requests outstanding
    tick(0, 0, 0, 0, 1);
    fixed_lat = 3;
    tick(1, 1, 0, 0, 0);
    tick(1, 1, 0, 0, 0);
    tick(1, 1, 1, 32'h103, 0);
    for (int n = 0; n < 20 && !b.if_valid; n++) tick(1, 1, 0, 0, 0);
    chk("redir_pc0", b.if_pc, 32'h100);
    tick(1, 1, 0, 0, 0);
    for (int n = 0; n < 20 && !b.if_valid; n++) tick(1, 1, 0, 0, 0);
    chk("redir_pc1", b.if_pc, 32'h104);
    // redirect coinciding with a response and a pop
    tick(0, 0, 0, 0, 1);
    fixed_lat = 1;
    for (int n = 0; n < 20 && !(buf_pc.size() != 0 && infl.size() != 0 && infl[0].due <= cyc); n++) tick(1, 1, 0, 0, 0);
    tick(1, 1, 1, 32'h200, 0);
    chk("flush_if_valid", 32'(b.if_valid), 32'h0);
    chk("flush_addr", b.imem_addr, 32'h200);
    for (int n = 0; n < 20 && !b.if_valid; n++) tick(1, 1, 0, 0, 0);
    chk("flush_first_pc", b.if_pc, 32'h200);
    // PC wrap at the top of the address space
    tick(1, 1, 1, 32'hFFFF_FFFD, 0);
    chk("wrap_start", b.imem_addr, 32'hFFFF_FFFC);
    for (int n = 0; n < 20 && m_pc != 32'h0; n++) tick(1, 1, 0, 0, 0);
    chk("wrap_addr", b.imem_addr, 32'h0);
    repeat (6) tick(1, 1, 0, 0, 0);
    // reset mid-stream with a full FIFO
    repeat (8) tick(1, 0, 0, 0, 0);
    chk("full_if_valid", 32'(b.if_valid), 32'h1);
    tick(1, 1, 0, 0, 1);
    chk("midrst_if_valid", 32'(b.if_valid), 32'h0);
    chk("midrst_addr", b.imem_addr, 32'h0);
    repeat (10) tick(1, 1, 0, 0, 0);
    // random traffic
    rand_lat = 1;
    for (int n = 0; n < 3000; n++)
      tick($urandom % 4 != 0, $urandom % 3 != 0, $urandom % 20 == 0, $urandom, $urandom % 300 == 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
